// File: rtl/frame_config_writer.sv
// frame_config_writer
// Turns a valid/ready stream of frame commands into FrameData/FrameStrobe
// for the fabric tile array. A command is one header word followed by
// NumRows data words. The data words fill the per-row FrameData registers.
// After one setup cycle, the addressed column/frame strobe line is pulsed
// for StrobeCycles cycles.
//
// Ports:
//   UserCLK      clock, all state on rising edge
//   reset        synchronous active-high reset
//   s_data       stream word (header or row data)
//   s_valid      s_data valid
//   s_ready      word accepted when s_valid && s_ready on a clock edge
//   FrameData    row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  column c, frame f at bit c*MaxFramesPerCol+f
//   busy         high whenever the FSM is not in IDLE
//   error        sticky protocol error flag (cleared only by reset)
//   frame_count  frames successfully strobed, wrapping at 16 bits
module frame_config_writer #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 2,
    parameter int unsigned NumColumns      = 4,
    parameter int unsigned StrobeCycles    = 2
) (
    input  logic                                  UserCLK,
    input  logic                                  reset,
    input  logic [FrameBitsPerRow-1:0]            s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  error,
    output logic [15:0]                           frame_count
);

    localparam int unsigned DataW   = NumRows * FrameBitsPerRow;
    localparam int unsigned StrobeW = NumColumns * MaxFramesPerCol;
    localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned CntW    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [7:0]  SyncWord = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DISCARD,
        SETUP,
        STROBE
    } state_t;

    state_t              state_q, state_d;
    logic [RowW-1:0]     row_idx_q, row_idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          frame_q, frame_d;
    logic [DataW-1:0]    frame_data_q, frame_data_d;
    logic [StrobeW-1:0]  strobe_q, strobe_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic                accept;
    logic                last_row;
    logic                hdr_sync_ok;
    logic                hdr_in_range;
    logic [31:0]         strobe_idx;

    // Handshake is gated by reset so no word is taken during a reset cycle.
    assign s_ready     = ready_q & ~reset;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign frame_count = frame_count_q;

    assign accept       = s_valid & s_ready;
    assign last_row     = (row_idx_q == RowW'(NumRows - 1));
    assign hdr_sync_ok  = (s_data[31:24] == SyncWord);
    assign hdr_in_range = (32'(s_data[23:16]) < NumColumns) &&
                          (32'(s_data[15:8])  < MaxFramesPerCol);
    assign strobe_idx   = 32'(col_q) * MaxFramesPerCol + 32'(frame_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        row_idx_d     = row_idx_q;
        cnt_d         = cnt_q;
        col_d         = col_q;
        frame_d       = frame_q;
        frame_data_d  = frame_data_q;
        error_d       = error_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!hdr_sync_ok) begin
                        error_d = 1'b1;
                    end else if (hdr_in_range) begin
                        col_d     = s_data[23:16];
                        frame_d   = s_data[15:8];
                        row_idx_d = '0;
                        state_d   = LOAD;
                    end else begin
                        // Out-of-range address: swallow the data words.
                        error_d   = 1'b1;
                        row_idx_d = '0;
                        state_d   = DISCARD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    frame_data_d[32'(row_idx_q) * FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    if (last_row) begin
                        state_d = SETUP;
                    end else begin
                        row_idx_d = row_idx_q + RowW'(1);
                    end
                end
            end
            DISCARD: begin
                if (accept) begin
                    if (last_row) begin
                        state_d = IDLE;
                    end else begin
                        row_idx_d = row_idx_q + RowW'(1);
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == CntW'(StrobeCycles - 1)) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ready_d  = (state_d == IDLE) || (state_d == LOAD) || (state_d == DISCARD);
        busy_d   = (state_d != IDLE);
        strobe_d = (state_d == STROBE) ? (StrobeW'(1) << strobe_idx) : '0;
    end

    // State and output registers.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q       <= IDLE;
            row_idx_q     <= '0;
            cnt_q         <= '0;
            col_q         <= '0;
            frame_q       <= '0;
            frame_data_q  <= '0;
            strobe_q      <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            frame_q       <= frame_d;
            frame_data_q  <= frame_data_d;
            strobe_q      <= strobe_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed self-checking bench for frame_config_writer.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_frame_config_writer;

    logic         UserCLK;
    logic         reset;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [63:0]  FrameData;
    logic [79:0]  FrameStrobe;
    logic         busy;
    logic         error;
    logic [15:0]  frame_count;

    int errors = 0;
    int checks = 0;

    frame_config_writer dut (
        .UserCLK     (UserCLK),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .error       (error),
        .frame_count (frame_count)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one cycle; called and returns on a falling edge.
    task automatic send(input logic [31:0] w);
        s_valid = 1'b1;
        s_data  = w;
        @(negedge UserCLK);
    endtask

    // Checks from the SETUP cycle through the return to IDLE.
    task automatic tail(input logic [63:0] data_exp, input int bitn, input logic [15:0] cnt_exp);
        logic [79:0] one;
        one = '0;
        one[bitn] = 1'b1;
        chk("setup_ready",  128'(s_ready),     128'(0));
        chk("setup_strobe", 128'(FrameStrobe), 128'(0));
        chk("setup_data",   128'(FrameData),   128'(data_exp));
        chk("setup_busy",   128'(busy),        128'(1));
        repeat (2) begin
            @(negedge UserCLK);
            chk("strobe_bit",   128'(FrameStrobe), 128'(one));
            chk("strobe_data",  128'(FrameData),   128'(data_exp));
            chk("strobe_ready", 128'(s_ready),     128'(0));
        end
        @(negedge UserCLK);
        chk("done_strobe", 128'(FrameStrobe), 128'(0));
        chk("done_ready",  128'(s_ready),     128'(1));
        chk("done_busy",   128'(busy),        128'(0));
        chk("done_count",  128'(frame_count), 128'(cnt_exp));
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;

        // Reset state
        repeat (2) @(negedge UserCLK);
        chk("rst_ready_low", 128'(s_ready), 128'(0));
        reset = 1'b0;
        #1;
        chk("rst_ready",  128'(s_ready),     128'(1));
        chk("rst_busy",   128'(busy),        128'(0));
        chk("rst_data",   128'(FrameData),   128'(0));
        chk("rst_strobe", 128'(FrameStrobe), 128'(0));
        chk("rst_error",  128'(error),       128'(0));
        chk("rst_count",  128'(frame_count), 128'(0));
        @(negedge UserCLK);

        // 1: column 1 frame 3 -> bit 23
        send(32'hA5_01_03_00);
        send(32'h1111_1111);
        send(32'h2222_2222);
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        tail({32'h2222_2222, 32'h1111_1111}, 23, 16'd1);
        chk("t1_error", 128'(error), 128'(0));

        // 2: bad sync, then valid command to column 0 frame 0
        send(32'h5A_00_00_00);
        s_valid = 1'b0;
        chk("t2_error", 128'(error), 128'(1));
        chk("t2_idle",  128'(busy),  128'(0));
        send(32'hA5_00_00_00);
        send(32'h3333_3333);
        send(32'h4444_4444);
        s_valid = 1'b0;
        tail({32'h4444_4444, 32'h3333_3333}, 0, 16'd2);
        chk("t2_error_sticky", 128'(error), 128'(1));

        // 3: column out of range, then frame out of range; both discarded
        send(32'hA5_04_00_00);
        send(32'h5555_5555);
        chk("t3_discard_busy",   128'(busy),        128'(1));
        chk("t3_discard_strobe", 128'(FrameStrobe), 128'(0));
        send(32'h6666_6666);
        s_valid = 1'b0;
        chk("t3_idle",   128'(busy),        128'(0));
        chk("t3_data",   128'(FrameData),   128'({32'h4444_4444, 32'h3333_3333}));
        chk("t3_strobe", 128'(FrameStrobe), 128'(0));
        send(32'hA5_00_14_00);
        send(32'h7777_7777);
        send(32'h8888_8888);
        s_valid = 1'b0;
        chk("t3b_idle",  128'(busy),        128'(0));
        chk("t3b_data",  128'(FrameData),   128'({32'h4444_4444, 32'h3333_3333}));
        chk("t3b_count", 128'(frame_count), 128'(2));
        send(32'hA5_01_00_00);
        send(32'h9999_9999);
        send(32'hAAAA_AAAA);
        s_valid = 1'b0;
        tail({32'hAAAA_AAAA, 32'h9999_9999}, 20, 16'd3);

        // 4: stall between data words; column 2 frame 1 -> bit 41
        send(32'hA5_02_01_00);
        send(32'hBBBB_BBBB);
        s_valid = 1'b0;
        s_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_busy",   128'(busy),        128'(1));
            chk("t4_stall_strobe", 128'(FrameStrobe), 128'(0));
            @(negedge UserCLK);
        end
        send(32'hCCCC_CCCC);
        s_valid = 1'b0;
        tail({32'hCCCC_CCCC, 32'hBBBB_BBBB}, 41, 16'd4);

        // 5: reset during first strobe cycle of column 3 frame 19 -> bit 79
        send(32'hA5_03_13_00);
        send(32'hDDDD_DDDD);
        send(32'hEEEE_EEEE);
        s_valid = 1'b0;
        @(negedge UserCLK);
        chk("t5_strobe79", 128'(FrameStrobe), 128'(1) << 79);
        reset = 1'b1;
        @(negedge UserCLK);
        chk("t5_strobe_drop", 128'(FrameStrobe), 128'(0));
        chk("t5_data_clr",    128'(FrameData),   128'(0));
        chk("t5_count_clr",   128'(frame_count), 128'(0));
        chk("t5_error_clr",   128'(error),       128'(0));
        chk("t5_ready_rst",   128'(s_ready),     128'(0));
        reset = 1'b0;
        #1;
        chk("t5_ready_after", 128'(s_ready), 128'(1));
        chk("t5_busy_after",  128'(busy),    128'(0));
        @(negedge UserCLK);

        // 6: back-to-back, next header held on the bus through the strobe
        send(32'hA5_02_05_00);
        send(32'h0123_4567);
        send(32'h89AB_CDEF);
        s_valid = 1'b1;
        s_data  = 32'hA5_00_13_00;
        tail({32'h89AB_CDEF, 32'h0123_4567}, 45, 16'd1);
        send(32'hA5_00_13_00);
        send(32'hFEDC_BA98);
        send(32'h7654_3210);
        s_valid = 1'b0;
        tail({32'h7654_3210, 32'hFEDC_BA98}, 19, 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
